// File: rtl/mc_sample_fifo.sv
`default_nettype none
// ============================================================================
// mc_sample_fifo : line buffer from the memory controller, unpacked into
//                  complex samples with framing and optional conjugation.
// Revision: 1.0
// ============================================================================
module mc_sample_fifo #(
  parameter int LINE_W    = 512,
  parameter int SAMPLE_W  = 64,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   conjI,
  input  logic                   loadInFifo,
  input  logic [LINE_W-1:0]      mcDataIn,
  input  logic                   sampleReady,
  output logic                   sampleValid,
  output logic [SAMPLE_W-1:0]    sampleOut,
  output logic                   lastSample,
  output logic                   frameDone,
  output logic                   full,
  output logic [$clog2(DEPTH):0] lineCount,
  output logic                   overflow
);

  localparam int SPL = LINE_W / SAMPLE_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int IW  = (SPL > 1) ? $clog2(SPL) : 1;
  localparam int FW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CW  = AW + 1;
  localparam int HW  = SAMPLE_W / 2;

  logic [LINE_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [IW-1:0]       r_idx;
  logic [FW-1:0]       r_frame;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic                r_frame_done;
  logic                r_mode;

  logic                w_valid;
  logic                w_full;
  logic                w_pop;
  logic                w_retire;
  logic                w_write;
  logic                w_frame_end;
  logic [LINE_W-1:0]   w_head;
  logic [SAMPLE_W-1:0] w_lane [SPL];
  logic [SAMPLE_W-1:0] w_raw;
  logic [HW-1:0]       w_imag;
  logic [HW-1:0]       w_imag_conj;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && sampleReady;
  assign w_retire    = w_pop && (r_idx == IW'(SPL - 1));
  assign w_write     = loadInFifo && !w_full;
  assign w_frame_end = (r_frame == FW'(FRAME_LEN - 1));

  assign w_head = r_mem[r_rd_ptr];

  generate
    for (genvar k = 0; k < SPL; k++) begin : g_lane
      assign w_lane[k] = w_head[k*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  assign w_raw  = w_lane[r_idx];
  assign w_imag = w_raw[HW-1:0];

  // The most negative value has no positive twin; clamp it to the positive max.
  assign w_imag_conj = (w_imag == {1'b1, {(HW-1){1'b0}}}) ? {1'b0, {(HW-1){1'b1}}}
                                                           : (HW'(0) - w_imag);

  assign sampleValid = w_valid;
  assign sampleOut   = w_valid ? {w_raw[SAMPLE_W-1:HW], (r_mode ? w_imag_conj : w_imag)}
                               : '0;
  assign lastSample  = w_valid && w_frame_end;
  assign frameDone   = r_frame_done;
  assign full        = w_full;
  assign lineCount   = r_count;
  assign overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop && w_frame_end;
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (loadInFifo && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_idx   <= w_retire ? '0 : r_idx + 1'b1;
        r_frame <= w_frame_end ? '0 : r_frame + 1'b1;
        if (w_retire) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
      case ({w_write, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Mode is latched only at job boundaries so a job never mixes conventions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (clr) begin
      r_mode <= conjI;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write && !rst && !clr) begin
      r_mem[r_wr_ptr] <= mcDataIn;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_sample_fifo.sv
`default_nettype none
// ============================================================================
// tb_mc_sample_fifo : self-checking bench for mc_sample_fifo.
// Revision: 1.0
// ============================================================================
module tb_mc_sample_fifo;

  localparam int LW = 512;
  localparam int SW = 64;
  localparam int DP = 16;
  localparam int FL = 1024;
  localparam int NS = LW / SW;

  logic          clk = 1'b0;
  logic          rst, clr, conjI, loadInFifo, sampleReady;
  logic [LW-1:0] mcDataIn;
  logic          sampleValid, lastSample, frameDone, full, overflow;
  logic [SW-1:0] sampleOut;
  logic [4:0]    lineCount;

  int total = 0;
  int bad   = 0;

  // Reference model: a flat queue of raw samples plus frame position.
  logic [SW-1:0] mq[$];
  int            m_fpos;
  bit            m_ovf, m_fd, m_mode;

  typedef struct {
    logic        ld;
    int          pat;
    logic        rdy;
    logic        cl;
    logic        cj;
    logic        ev;
    logic [63:0] eo;
    logic [4:0]  ecnt;
  } vec_t;
  vec_t tbl[$];

  mc_sample_fifo #(.LINE_W(LW), .SAMPLE_W(SW), .DEPTH(DP), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .clr(clr), .conjI(conjI), .loadInFifo(loadInFifo),
    .mcDataIn(mcDataIn), .sampleReady(sampleReady), .sampleValid(sampleValid),
    .sampleOut(sampleOut), .lastSample(lastSample), .frameDone(frameDone),
    .full(full), .lineCount(lineCount), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic ld, int pat, logic rdy, logic cl, logic cj,
                               logic ev, logic [63:0] eo, logic [4:0] ecnt);
    vec_t v;
    v.ld = ld; v.pat = pat; v.rdy = rdy; v.cl = cl; v.cj = cj;
    v.ev = ev; v.eo = eo; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [LW-1:0] pat_line(int p);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NS; k++) begin
      if (p == 1) l[k*SW +: SW] = {32'(k + 1), 32'(-(k + 1))};
      else if (p == 2) l[k*SW +: SW] = {32'(100 + k), (k == 0) ? 32'd5 :
                                        (k == 1) ? 32'h8000_0000 : 32'(k)};
    end
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    for (int k = 0; k < NS; k++) if ($urandom_range(7) == 0) l[k*SW +: 32] = 32'h8000_0000;
    return l;
  endfunction

  // Conjugate from the arithmetic definition: negate, then clamp to the signed max.
  function automatic logic [63:0] exp_sample(logic [63:0] s, bit md);
    longint im, r;
    if (!md) return s;
    im = longint'($signed(s[31:0]));
    r  = -im;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    return {s[63:32], r[31:0]};
  endfunction

  function automatic int m_lines();
    return (mq.size() + NS - 1) / NS;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic [LW-1:0] d, input logic rdy,
                       input logic cl, input logic cj, input logic rs);
    loadInFifo = ld; mcDataIn = d; sampleReady = rdy; clr = cl; conjI = cj; rst = rs;
    #1;
  endtask

  task automatic model_step();
    int lines;
    bit pop;
    if (rst || clr) begin
      mq.delete(); m_fpos = 0; m_ovf = 0; m_fd = 0;
      m_mode = rst ? 1'b0 : conjI;
      return;
    end
    lines = m_lines();
    pop   = (mq.size() > 0) && sampleReady;
    m_fd  = pop && (m_fpos == FL - 1);
    if (pop) begin
      void'(mq.pop_front());
      m_fpos = (m_fpos + 1) % FL;
    end
    if (loadInFifo) begin
      if (lines == DP) m_ovf = 1;
      else for (int k = 0; k < NS; k++) mq.push_back(mcDataIn[k*SW +: SW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model();
    int n;
    logic [63:0] eo;
    n  = mq.size();
    eo = (n > 0) ? exp_sample(mq[0], m_mode) : 64'h0;
    chk("valid", sampleValid, 64'(n > 0));
    chk("sample", sampleOut, eo);
    chk("last", lastSample, 64'((n > 0) && (m_fpos == FL - 1)));
    chk("frame_done", frameDone, 64'(m_fd));
    chk("full", full, 64'(m_lines() == DP));
    chk("line_count", lineCount, 64'(m_lines()));
    chk("overflow", overflow, 64'(m_ovf));
  endtask

  task automatic step_chk(input logic ld, input logic [LW-1:0] d, input logic rdy,
                          input logic cl, input logic cj, input logic rs);
    drive(ld, d, rdy, cl, cj, rs);
    check_model();
    tick();
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (mq.size() > 0 && c < budget) begin
      step_chk(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      c++;
    end
    chk("drain_timeout", 64'(mq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int written, cyc, lastc, fdc;
    bit ld;

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_valid", sampleValid, 0);
    chk("rst_out", sampleOut, 0);
    chk("rst_last", lastSample, 0);
    chk("rst_fd", frameDone, 0);
    chk("rst_full", full, 0);
    chk("rst_cnt", lineCount, 0);
    chk("rst_ovf", overflow, 0);

    // Single line LSB-first, then a conjugated line with the clamp corner.
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 64'h0, 0));
    for (int i = 0; i < NS; i++)
      tbl.push_back(mkv(0, 0, 1, 0, 0, 1, {32'(i + 1), 32'(-(i + 1))}, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 64'h0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 64'h0, 0));
    tbl.push_back(mkv(1, 2, 0, 0, 0, 0, 64'h0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, {32'd100, 32'hFFFF_FFFB}, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 1, {32'd100, 32'hFFFF_FFFB}, 1));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 1, {32'd101, 32'h7FFF_FFFF}, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 1, {32'd102, 32'hFFFF_FFFE}, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 64'h0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].ld, pat_line(tbl[i].pat), tbl[i].rdy, tbl[i].cl, tbl[i].cj, 1'b0);
      chk($sformatf("tbl%0d_valid", i), sampleValid, tbl[i].ev);
      chk($sformatf("tbl%0d_out", i), sampleOut, tbl[i].eo);
      chk($sformatf("tbl%0d_cnt", i), lineCount, tbl[i].ecnt);
      tick();
    end

    // Fill to full, overflow on the 17th write, then flush.
    for (int i = 0; i < DP; i++) step_chk(1'b1, rand_line(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rand_line(), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full16", full, 1);
    chk("t2_ovf16", overflow, 0);
    check_model();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf17", overflow, 1);
    chk("t2_cnt17", lineCount, 16);
    check_model();
    tick();
    step_chk(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_clr_ovf", overflow, 0);
    chk("t2_clr_cnt", lineCount, 0);

    // Write coincident with a line-retiring pop, at 16 and at 15 lines.
    for (int pass = 0; pass < 2; pass++) begin
      step_chk(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DP - pass; i++) step_chk(1'b1, rand_line(), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < NS - 1; i++) step_chk(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      step_chk(1'b1, rand_line(), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t5_ovf_p%0d", pass), overflow, (pass == 0) ? 1 : 0);
      chk($sformatf("t5_cnt_p%0d", pass), lineCount, 15);
      check_model();
      tick();
      drain(400);
    end

    // Two full frames streamed with random back-pressure.
    step_chk(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    written = 0; cyc = 0; lastc = 0; fdc = 0;
    while ((written < 2 * FL / NS || mq.size() > 0) && cyc < 20000) begin
      ld = (written < 2 * FL / NS) && (m_lines() < DP) && ($urandom_range(3) != 0);
      drive(ld, rand_line(), 1'($urandom_range(2) != 0), 1'b0, 1'b0, 1'b0);
      check_model();
      if (lastSample && sampleReady) lastc++;
      if (frameDone) fdc++;
      tick();
      if (ld) written++;
      cyc++;
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_model();
    if (frameDone) fdc++;
    tick();
    chk("t4_timeout", 64'(cyc < 20000), 1);
    chk("t4_last_pops", lastc, 2);
    chk("t4_frame_done", fdc, 2);

    // Reset mid-line in conjugate mode; next job must be plain.
    step_chk(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step_chk(1'b1, pat_line(2), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NS / 2; i++) step_chk(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step_chk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid", sampleValid, 0);
    chk("t6_out", sampleOut, 0);
    chk("t6_last", lastSample, 0);
    chk("t6_full", full, 0);
    chk("t6_cnt", lineCount, 0);
    tick();
    step_chk(1'b1, pat_line(2), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_plain0", sampleOut, {32'd100, 32'd5});
    check_model();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_plain1", sampleOut, {32'd101, 32'h8000_0000});
    tick();

    // Unconstrained random traffic: heavy fill first, then heavy drain.
    for (int c = 0; c < 3000; c++) begin
      step_chk(1'($urandom_range(1)), rand_line(),
               1'($urandom_range(3) < ((c < 1500) ? 1 : 3)),
               1'($urandom_range(79) == 0), 1'($urandom_range(1)),
               1'($urandom_range(499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
